// File: rtl/fifo_read_streamer_if.sv
// Bundles the async_fifo read port and the downstream valid/ready stream of fifo_read_streamer.
// p_word_count and COUNT_BITS exist only when FIFO_RD_STREAM_COUNT_EN is defined.
interface fifo_read_streamer_if #(
    parameter int BITS = 32
`ifdef FIFO_RD_STREAM_COUNT_EN
    , parameter int COUNT_BITS = 16
`endif
);
    logic            p_read_en;
    logic [BITS-1:0] p_read_data;
    logic            p_read_empty;
    logic            p_out_valid;
    logic            p_out_ready;
    logic [BITS-1:0] p_out_data;
`ifdef FIFO_RD_STREAM_COUNT_EN
    logic [COUNT_BITS-1:0] p_word_count;
`endif

    // The streamer drives master; the FIFO and the downstream sink together form slave.
    modport master (
        input  p_read_data, p_read_empty, p_out_ready,
`ifdef FIFO_RD_STREAM_COUNT_EN
        output p_word_count,
`endif
        output p_read_en, p_out_valid, p_out_data
    );

    modport slave (
        output p_read_data, p_read_empty, p_out_ready,
`ifdef FIFO_RD_STREAM_COUNT_EN
        input  p_word_count,
`endif
        input  p_read_en, p_out_valid, p_out_data
    );
endinterface

// File: rtl/fifo_read_streamer.sv
// Read-side async_fifo consumer: pops words into a small skid buffer and streams them out as valid/ready.
// Defining FIFO_RD_STREAM_COUNT_EN adds a delivered-word counter on p_word_count.
module fifo_read_streamer #(
    parameter int BITS      = 32,
    parameter int BUF_DEPTH = 4
`ifdef FIFO_RD_STREAM_COUNT_EN
    , parameter int COUNT_BITS = 16
`endif
) (
    input logic                  read_clk,
    input logic                  read_rst_n,
    fifo_read_streamer_if.master bus
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [OCC_W-1:0] POP_LIMIT = OCC_W'(BUF_DEPTH - 1);

    logic [BITS-1:0]  r_buf [BUF_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             r_inflight;

    logic [OCC_W-1:0] w_level;
    logic [OCC_W-1:0] w_occ_next;
    logic             w_pop;
    logic             w_capture;
    logic             w_out_valid;
    logic             w_transfer;

    // The in-flight word already owns a slot, so it counts against the pop budget.
    assign w_level     = r_occ + OCC_W'(r_inflight);
    assign w_pop       = read_rst_n && !bus.p_read_empty && (w_level < POP_LIMIT);
    assign w_capture   = r_inflight;
    assign w_out_valid = (r_occ != '0);
    assign w_transfer  = w_out_valid && bus.p_out_ready;

    assign bus.p_read_en   = w_pop;
    assign bus.p_out_valid = w_out_valid;
    assign bus.p_out_data  = w_out_valid ? r_buf[r_rd_ptr] : '0;

    always_comb begin
        // NOTE: default assigned first so every path drives w_occ_next and no latch is inferred.
        w_occ_next = r_occ;
        unique case ({w_capture, w_transfer})
            2'b10:   w_occ_next = r_occ + OCC_W'(1);
            2'b01:   w_occ_next = r_occ - OCC_W'(1);
            default: w_occ_next = r_occ;
        endcase
    end

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_occ      <= w_occ_next;
            r_inflight <= w_pop;
            if (w_capture) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_transfer) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: storage is deliberately not reset; p_out_data is masked while empty so stale entries never leak.
    always_ff @(posedge read_clk) begin
        if (w_capture) r_buf[r_wr_ptr] <= bus.p_read_data;
    end

`ifdef FIFO_RD_STREAM_COUNT_EN
    logic [COUNT_BITS-1:0] r_word_count;

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) r_word_count <= '0;
        else if (w_transfer) r_word_count <= r_word_count + COUNT_BITS'(1);
    end

    assign bus.p_word_count = r_word_count;
`endif
endmodule
